ov7670_capture_crop: RTL
========================

// Module: ov7670_capture_crop
// PURPOSE
//  Upstream of the frame-buffer/VGA path. Samples the OV7670 byte stream (VSYNC, HREF, D[7:0]) on PCLK.
//  Packs byte pairs into RGB565 pixels and crops a CROP_W x CROP_H window from the IMG_W x IMG_H frame.
//  Emits write_en/addr/data_out for the dual-port pixel RAM write port, which is clocked by the same PCLK.
//  The VGA side reads that RAM with row-major addr = row*CROP_W + col.
// PARAMETERS
//  IMG_W   320  camera pixels per HREF line (QVGA)
//  IMG_H   240  camera lines per frame
//  CROP_W  235  stored pixels per line
//  CROP_H  235  stored lines per frame
//  X_OFF   42   first camera column stored
//  Y_OFF   2    first camera line stored; requires X_OFF+CROP_W<=IMG_W and Y_OFF+CROP_H<=IMG_H
//  ADDR_W  16   RAM address width; CROP_W*CROP_H (55225) must fit
// PORTS
//  clk          in   1       camera PCLK; all logic on posedge
//  reset_n      in   1       async active-low reset
//  enable       in   1       arm capture; sampled only at frame start
//  vsync        in   1       camera VSYNC, high = vertical blank
//  href         in   1       camera HREF, high = valid bytes on data_in
//  data_in      in   8       camera byte; high byte of RGB565 comes first
//  data_out     out  16      packed pixel {R5,G6,B5}
//  write_en     out  1       one-cycle RAM write strobe
//  addr         out  ADDR_W  RAM write address for data_out
//  frame_active out  1       high while a frame is being captured
//  frame_done   out  1       one-cycle pulse when a captured frame ends
//  line_err     out  1       sticky per frame: bad line length or line count
//  frame_count  out  8       captured frames, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, byte phase 0.
//  vsync and href are registered once (vs_q, hr_q) for edge detection. Data path uses the live href/data_in.
//  FSM:
//   IDLE     : if enable go to WAIT_VS.
//   WAIT_VS  : on vsync falling edge (vs_q=1, vsync=0):
//              if enable -> CAPTURE, frame_active<=1, clear col/row/addr/phase/line_err; else -> IDLE.
//   CAPTURE  : on vsync rising edge -> WAIT_VS, frame_active<=0, frame_done<=1 for 1 cycle, frame_count++.
//  enable low mid-frame has no effect until the next frame start; the current frame completes.
//  Byte pairing (CAPTURE, href=1):
//   phase 0: hi<=data_in, phase<=1.
//   phase 1: pixel={hi,data_in}, phase<=0, col++.
//  Crop/write: when phase 1 completes pixel at (col,row) with X_OFF<=col<X_OFF+CROP_W
//   and Y_OFF<=row<Y_OFF+CROP_H, then next cycle write_en=1, data_out=pixel, addr=wr_ptr;
//   wr_ptr++ after each write. Latency: second byte edge -> write_en = 1 clk.
//  data_out/addr hold their last value when write_en=0.
//  Line end (href falling, hr_q=1 & href=0): row++, col<=0, phase<=0.
//   line_err<=1 if col!=IMG_W or phase==1 (odd byte count).
//  Frame end in CAPTURE: line_err<=1 if row!=IMG_H. frame_done and that line_err update occur in the same cycle.
//  Overflow guard: wr_ptr saturates at CROP_W*CROP_H-1; no write once CROP_W*CROP_H pixels are stored.
//  Lines with row>=IMG_H are ignored for writes.
//  href high outside CAPTURE: ignored, no writes.
//  Simultaneous vsync rise and href high: vsync wins; frame ends and that byte is dropped.
//  Reset asserted mid-frame: immediate return to IDLE, write_en=0 same instant (async), no partial frame_done.
// STRUCTURE
//  Shared package cam_pkg: cap_state_t enum {IDLE,WAIT_VS,CAPTURE}; typedef logic [15:0] rgb565_t;
//  localparams QVGA_W=320, QVGA_H=240, CROP_PIX=CROP_W*CROP_H.
//  One sub-module edge_detect (registered rise/fall of a 1-bit signal), instantiated for vsync and href.
//  Counters col (10b) and row (9b) plus wr_ptr; one always_ff for FSM, one for datapath.
// TESTING
//  1 Reset, enable=1, BFM frame 320x240, bytes hi=8'hF8 lo=8'h1F -> 55225 writes of 16'hF81F,
//    first addr 0, last addr 55224, one frame_done, frame_count=1, line_err=0.
//  2 Pixel (col,row)=(42,2) carries 16'h1234 -> written at addr 0;
//    (276,236) carries 16'hABCD -> addr 55224; col 41 and col 277 are never written.
//  3 One line with 639 bytes (odd) -> line_err=1 at that href fall;
//    next line realigned (phase 0); line_err cleared at next frame start.
//  4 enable dropped at row 100 -> frame completes with 55225 writes;
//    next vsync fall -> IDLE, no writes in following frame.
//  5 reset_n pulsed low at row 50 -> outputs 0 at once; after release + enable,
//    capture waits for a fresh vsync fall, addr restarts at 0.
//  6 Frame of 250 lines -> wr_ptr saturates at 55224, no extra writes, line_err=1 at vsync rise.

Source files
------------

// File: rtl/ov7670_capture_crop_pkg.sv
// Shared types and default geometry for the OV7670 capture/crop path.
package cam_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} cap_state_t;
    typedef logic [15:0] rgb565_t;

    localparam int QVGA_W     = 320;
    localparam int QVGA_H     = 240;
    localparam int CROP_W_DEF = 235;
    localparam int CROP_H_DEF = 235;
    localparam int CROP_PIX   = CROP_W_DEF * CROP_H_DEF;

    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction
endpackage

// File: rtl/ov7670_capture_crop_if.sv
// Camera byte stream in, pixel-RAM write port and frame status out.
interface ov7670_capture_crop_if #(parameter int ADDR_W = 16);
    import cam_pkg::*;

    logic              enable;
    logic              vsync;
    logic              href;
    logic [7:0]        data_in;
    rgb565_t           data_out;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic              frame_active;
    logic              frame_done;
    logic              line_err;
    logic [7:0]        frame_count;

    modport master (
        output enable, vsync, href, data_in,
        input  data_out, write_en, addr, frame_active, frame_done, line_err, frame_count
    );
    modport slave (
        input  enable, vsync, href, data_in,
        output data_out, write_en, addr, frame_active, frame_done, line_err, frame_count
    );
endinterface

// File: rtl/ov7670_capture_crop_edge_detect.sv
// One-flop edge detector: compares the registered copy against the live input.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= i_d;
    end

    assign o_rise = ~r_q & i_d;
    assign o_fall = r_q & ~i_d;
endmodule

// File: rtl/ov7670_capture_crop.sv
// OV7670 RGB565 byte-pair packer with a row-major crop window into pixel RAM.
module ov7670_capture_crop
    import cam_pkg::*;
#(
    parameter int IMG_W  = QVGA_W,
    parameter int IMG_H  = QVGA_H,
    parameter int CROP_W = CROP_W_DEF,
    parameter int CROP_H = CROP_H_DEF,
    parameter int X_OFF  = 42,
    parameter int Y_OFF  = 2,
    parameter int ADDR_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    ov7670_capture_crop_if.slave cam
);
    localparam int L_PIX = CROP_W * CROP_H;

    cap_state_t        r_state, w_state_nxt;
    logic [9:0]        r_col;
    logic [8:0]        r_row;
    logic [ADDR_W-1:0] r_wr_ptr, r_addr;
    logic              r_full, r_phase;
    logic [7:0]        r_hi, r_frame_count;
    rgb565_t           r_data_out;
    logic              r_write_en, r_frame_active, r_frame_done, r_line_err;
    logic              w_vs_rise, w_vs_fall, w_hr_fall, w_unused_hr_rise;
    logic              w_start, w_in_win;

    edge_detect u_vs (.clk(clk), .reset_n(reset_n), .i_d(cam.vsync),
                      .o_rise(w_vs_rise), .o_fall(w_vs_fall));
    edge_detect u_hr (.clk(clk), .reset_n(reset_n), .i_d(cam.href),
                      .o_rise(w_unused_hr_rise), .o_fall(w_hr_fall));

    assign w_start  = (r_state == WAIT_VS) && w_vs_fall && cam.enable;
    assign w_in_win = (r_col >= 10'(X_OFF)) && (r_col < 10'(X_OFF + CROP_W)) &&
                      (r_row >= 9'(Y_OFF))  && (r_row < 9'(Y_OFF + CROP_H));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cam.enable) w_state_nxt = WAIT_VS;
            WAIT_VS: if (w_vs_fall)  w_state_nxt = cam.enable ? CAPTURE : IDLE;
            CAPTURE: if (w_vs_rise)  w_state_nxt = WAIT_VS;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col          <= '0;
            r_row          <= '0;
            r_wr_ptr       <= '0;
            r_addr         <= '0;
            r_full         <= 1'b0;
            r_phase        <= 1'b0;
            r_hi           <= '0;
            r_data_out     <= '0;
            r_write_en     <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_line_err     <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_write_en   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_frame_active <= 1'b1;
                r_col          <= '0;
                r_row          <= '0;
                r_wr_ptr       <= '0;
                r_full         <= 1'b0;
                r_phase        <= 1'b0;
                r_line_err     <= 1'b0;
            end else if (r_state == CAPTURE) begin
                // vsync rise takes priority: a byte arriving in the same cycle is dropped
                if (w_vs_rise) begin
                    r_frame_active <= 1'b0;
                    r_frame_done   <= 1'b1;
                    r_frame_count  <= r_frame_count + 8'd1;
                    if (r_row != 9'(IMG_H)) r_line_err <= 1'b1;
                end else if (w_hr_fall) begin
                    r_row   <= r_row + 9'd1;
                    r_col   <= '0;
                    r_phase <= 1'b0;
                    if ((r_col != 10'(IMG_W)) || r_phase) r_line_err <= 1'b1;
                end else if (cam.href) begin
                    if (!r_phase) begin
                        r_hi    <= cam.data_in;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_col   <= r_col + 10'd1;
                        if (w_in_win && !r_full) begin
                            r_write_en <= 1'b1;
                            r_data_out <= pack_rgb565(r_hi, cam.data_in);
                            r_addr     <= r_wr_ptr;
                            // pointer parks on the last slot; r_full blocks further writes
                            if (r_wr_ptr == ADDR_W'(L_PIX - 1)) r_full <= 1'b1;
                            else                                r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign cam.data_out     = r_data_out;
    assign cam.write_en     = r_write_en;
    assign cam.addr         = r_addr;
    assign cam.frame_active = r_frame_active;
    assign cam.frame_done   = r_frame_done;
    assign cam.line_err     = r_line_err;
    assign cam.frame_count  = r_frame_count;
endmodule
